// File: rtl/fir_frame_ctrl.sv
// Frame sequencer in front of fir8: flushes the delay line with TAPS zeros, streams
// frame_len source samples, forwards only the outputs of those samples, then pulses done.
module fir_frame_ctrl #(
    parameter int TAPS     = 8,
    parameter int LEN_W    = 16,
    parameter int DRAIN_TO = 256
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [LEN_W-1:0] frame_len,
    input  logic [15:0]      src_data,
    input  logic             src_valid,
    output logic             src_ready,
    output logic [15:0]      fir_sample_in,
    output logic             fir_valid_in,
    input  logic             fir_ready_in,
    input  logic [15:0]      fir_sample_out,
    input  logic             fir_valid_out,
    output logic [15:0]      dst_data,
    output logic             dst_valid,
    output logic             busy,
    output logic             done,
    output logic             timeout,
    output logic [LEN_W-1:0] out_count,
    output logic [LEN_W-1:0] clip_count
);

    localparam int CNT_W = $clog2(TAPS + 1);
    localparam int WD_W  = $clog2(DRAIN_TO);
    localparam logic [CNT_W-1:0] TAPS_C  = CNT_W'(TAPS);
    localparam logic [CNT_W-1:0] TAPS_M1 = CNT_W'(TAPS - 1);
    localparam logic [WD_W-1:0]  WD_LAST = WD_W'(DRAIN_TO - 1);

    typedef enum logic [2:0] {IDLE, FLUSH, RUN, DRAIN, DONE} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] len_q, in_cnt, out_nxt;
    logic [CNT_W-1:0] flush_cnt, disc_cnt, disc_nxt;
    logic [WD_W-1:0]  wd_cnt;
    logic             start_ok, accept_flush, accept_run, active;
    logic             discard, forward, final_out, wd_expire, is_clip;

    // Classification of the current cycle; reads only registers and inputs.
    always_comb begin
        start_ok     = (state == IDLE) && start && !abort;
        accept_flush = (state == FLUSH) && fir_ready_in;
        accept_run   = (state == RUN) && src_valid && fir_ready_in;
        active       = ((state == FLUSH) || (state == RUN) || (state == DRAIN)) && !abort;
        discard      = active && fir_valid_out && (disc_cnt != TAPS_C);
        forward      = active && fir_valid_out && (disc_cnt == TAPS_C) && (out_count < len_q);
        disc_nxt     = disc_cnt + CNT_W'(discard);
        out_nxt      = out_count + LEN_W'(forward);
        final_out    = (disc_nxt == TAPS_C) && (out_nxt == len_q);
        wd_expire    = !fir_valid_out && (wd_cnt == WD_LAST);
        is_clip      = (fir_sample_out == 16'h7FFF) || (fir_sample_out == 16'h8000);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        state_nxt     = state;
        src_ready     = 1'b0;
        fir_valid_in  = 1'b0;
        fir_sample_in = 16'h0000;
        done          = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (start_ok) state_nxt = FLUSH;
            end
            FLUSH: begin
                fir_valid_in = 1'b1;
                if (accept_flush && (flush_cnt == TAPS_M1))
                    state_nxt = (len_q == '0) ? DRAIN : RUN;
            end
            RUN: begin
                fir_sample_in = src_data;
                fir_valid_in  = src_valid;
                src_ready     = fir_ready_in;
                if (accept_run && (in_cnt == len_q - LEN_W'(1))) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (final_out || wd_expire) state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q      <= '0;
            in_cnt     <= '0;
            flush_cnt  <= '0;
            disc_cnt   <= '0;
            wd_cnt     <= '0;
            out_count  <= '0;
            clip_count <= '0;
            timeout    <= 1'b0;
            dst_data   <= 16'h0000;
            dst_valid  <= 1'b0;
        end else begin
            // NOTE: non-blocking throughout so every register sees pre-edge values.
            dst_valid <= forward;
            if (forward) dst_data <= fir_sample_out;
            if (start_ok) begin
                len_q      <= frame_len;
                in_cnt     <= '0;
                flush_cnt  <= '0;
                disc_cnt   <= '0;
                out_count  <= '0;
                clip_count <= '0;
                timeout    <= 1'b0;
            end else begin
                if (accept_flush && !abort) flush_cnt <= flush_cnt + CNT_W'(1);
                if (accept_run && !abort)   in_cnt    <= in_cnt + LEN_W'(1);
                disc_cnt  <= disc_nxt;
                out_count <= out_nxt;
                if (forward && is_clip && (clip_count != '1))
                    clip_count <= clip_count + LEN_W'(1);
                if ((state == DRAIN) && !abort && !final_out && wd_expire)
                    timeout <= 1'b1;
            end
            // Watchdog only measures silence inside DRAIN.
            if ((state != DRAIN) || fir_valid_out) wd_cnt <= '0;
            else                                   wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

endmodule

// File: tb/tb_fir_frame_ctrl.sv
// Scoreboard bench for fir_frame_ctrl with a 1-cycle passthrough fir8 model.
module tb_fir_frame_ctrl;

    localparam int TAPS     = 8;
    localparam int LEN_W    = 16;
    localparam int DRAIN_TO = 32;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [LEN_W-1:0] frame_len = '0;
    logic [15:0]      src_data = 16'h0;
    logic             src_valid = 1'b0;
    logic             src_ready;
    logic [15:0]      fir_sample_in;
    logic             fir_valid_in;
    logic             fir_ready_in = 1'b1;
    logic [15:0]      fir_sample_out = 16'h0;
    logic             fir_valid_out = 1'b0;
    logic [15:0]      dst_data;
    logic             dst_valid;
    logic             busy, done, timeout;
    logic [LEN_W-1:0] out_count, clip_count;

    always #5 clk = ~clk;

    fir_frame_ctrl #(.TAPS(TAPS), .LEN_W(LEN_W), .DRAIN_TO(DRAIN_TO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .frame_len(frame_len),
        .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
        .fir_sample_in(fir_sample_in), .fir_valid_in(fir_valid_in), .fir_ready_in(fir_ready_in),
        .fir_sample_out(fir_sample_out), .fir_valid_out(fir_valid_out),
        .dst_data(dst_data), .dst_valid(dst_valid), .busy(busy), .done(done),
        .timeout(timeout), .out_count(out_count), .clip_count(clip_count)
    );

    typedef struct { logic [15:0] data; int rel; } ent_t;
    ent_t sb_q[$];
    ent_t log_q[$];
    ent_t mon_e;

    int n_cmp = 0, n_bad = 0;
    int cyc = 0, start_cyc = 0, mon_rel = 0, drv_idx = 0;
    int src_acc = 0, src_base = 0, src_n = 0, log_base = 0;
    int emitted = 0, out_limit = 32'h3FFF_FFFF;
    int done_cnt = 0, done_rel = -1, last_fv_rel = -1;
    logic [15:0] src_vec [8];
    bit src_en = 0, src_alt = 0, src_phase = 0, bp_en = 0, sb_relaxed = 0;
    bit fir_acc_q = 0;
    logic [15:0] fir_acc_d = 16'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // fir8 stand-in: each accepted input reappears one cycle later, up to out_limit outputs.
    always @(posedge clk) begin
        if (fir_acc_q && (emitted < out_limit)) begin
            fir_valid_out <= 1'b1;
            emitted       <= emitted + 1;
        end else begin
            fir_valid_out <= 1'b0;
        end
        fir_sample_out <= fir_acc_d;
    end

    always @(negedge clk) begin
        src_phase    = src_alt ? ~src_phase : 1'b1;
        drv_idx      = src_acc - src_base;
        src_valid    = src_en && src_phase && (drv_idx < src_n);
        if (drv_idx < src_n) src_data = src_vec[drv_idx];
        fir_ready_in = !(bp_en && ((cyc - start_cyc) >= 3) && ((cyc - start_cyc) <= 5));
    end

    // Monitor: samples mid-cycle once the drivers have settled.
    always @(negedge clk) begin
        #1;
        mon_rel = cyc - start_cyc;
        if (fir_valid_in && fir_ready_in) begin
            log_q.push_back('{fir_sample_in, mon_rel});
            fir_acc_q = 1'b1;
            fir_acc_d = fir_sample_in;
        end else begin
            fir_acc_q = 1'b0;
        end
        if (src_valid && src_ready) src_acc++;
        if (fir_valid_out) last_fv_rel = mon_rel;
        if (dst_valid && !sb_relaxed) begin
            check("dst_expected", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("dst_data", dst_data, mon_e.data);
                if (mon_e.rel >= 0) check("dst_cycle", mon_rel, mon_e.rel);
            end
        end
        if (done) begin
            done_cnt++;
            done_rel = mon_rel;
        end
    end

    task automatic set_src(input logic [15:0] a, b, c, d);
        src_vec[0] = a; src_vec[1] = b; src_vec[2] = c; src_vec[3] = d;
        src_n = 4;
    endtask

    task automatic expect_out(input logic [15:0] d, input int rel);
        sb_q.push_back('{d, rel});
    endtask

    task automatic start_frame(input logic [LEN_W-1:0] len);
        @(negedge clk);
        frame_len = len;
        start     = 1'b1;
        start_cyc = cyc;
        src_base  = src_acc;
        log_base  = log_q.size();
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_rel(input int r);
        while ((cyc - start_cyc) < r) @(negedge clk);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int  d0;
        bit  seen;
        d0   = done_cnt;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            #2;
            if (done_cnt != d0) seen = 1;
        end
        check({tag, "_done_seen"}, seen, 1);
    endtask

    task automatic check_log(input string tag, input int n_samp);
        int n;
        n = log_q.size() - log_base;
        check({tag, "_acc_count"}, n, TAPS + n_samp);
        for (int i = 0; i < TAPS + n_samp && i < n; i++) begin
            if (i < TAPS) check({tag, "_acc_zero"}, log_q[log_base + i].data, 16'h0);
            else          check({tag, "_acc_samp"}, log_q[log_base + i].data, src_vec[i - TAPS]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1);
    end

    initial begin
        int d0, n_stall;

        // Reset values
        #2;
        check("rst_busy", busy, 0);
        check("rst_src_ready", src_ready, 0);
        check("rst_fir_valid_in", fir_valid_in, 0);
        check("rst_fir_sample_in", fir_sample_in, 0);
        check("rst_dst_valid", dst_valid, 0);
        check("rst_dst_data", dst_data, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_out_count", out_count, 0);
        check("rst_clip_count", clip_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #2;
        check("idle_no_start_busy", busy, 0);

        // Nominal frame
        set_src(16'h7FFF, 16'h8000, 16'h0001, 16'h0002);
        src_en = 1;
        expect_out(16'h7FFF, 11);
        expect_out(16'h8000, 12);
        expect_out(16'h0001, 13);
        expect_out(16'h0002, 14);
        start_frame(4);
        #2;
        check("nom_flush_valid_in", fir_valid_in, 1);
        check("nom_flush_src_ready", src_ready, 0);
        check("nom_flush_busy", busy, 1);
        wait_done("nom", 100);
        check("nom_done_cycle", done_rel, 14);
        check("nom_out_count", out_count, 4);
        check("nom_clip_count", clip_count, 2);
        check("nom_busy_in_done", busy, 1);
        check_log("nom", 4);
        if (log_q.size() >= log_base + 9) begin
            check("nom_first_zero_cycle", log_q[log_base].rel, 1);
            check("nom_first_samp_cycle", log_q[log_base + 8].rel, 9);
        end
        @(negedge clk);
        #2;
        check("nom_idle_busy", busy, 0);
        check("nom_idle_done", done, 0);
        check("nom_sb_empty", sb_q.size(), 0);

        // Backpressure and source gaps
        set_src(16'h1234, 16'hFFFF, 16'h7FFF, 16'h0005);
        src_alt = 1;
        bp_en   = 1;
        for (int i = 0; i < 4; i++) expect_out(src_vec[i], -1);
        start_frame(4);
        wait_done("bp", 200);
        check("bp_done_late", done_rel >= 17, 1);
        check("bp_out_count", out_count, 4);
        check("bp_clip_count", clip_count, 1);
        check_log("bp", 4);
        n_stall = 0;
        for (int i = log_base; i < log_q.size(); i++)
            if (log_q[i].rel >= 3 && log_q[i].rel <= 5) n_stall++;
        check("bp_no_accept_when_stalled", n_stall, 0);
        src_alt = 0;
        bp_en   = 0;
        @(negedge clk);
        check("bp_sb_empty", sb_q.size(), 0);

        // Zero length
        set_src(16'h0AAA, 16'h0BBB, 16'h0CCC, 16'h0DDD);
        start_frame(0);
        wait_done("zero", 100);
        check("zero_done_cycle", done_rel, 10);
        check("zero_out_count", out_count, 0);
        check_log("zero", 0);

        // Watchdog: the filter falls silent after 10 outputs
        set_src(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        expect_out(16'h0100, 11);
        expect_out(16'h0200, 12);
        out_limit = emitted + 10;
        start_frame(4);
        wait_done("wd", DRAIN_TO + 100);
        check("wd_timeout", timeout, 1);
        check("wd_out_count", out_count, 2);
        check("wd_last_out", last_fv_rel, 11);
        check("wd_delay_lo", (done_rel - last_fv_rel) >= DRAIN_TO, 1);
        check("wd_delay_hi", (done_rel - last_fv_rel) <= DRAIN_TO + 3, 1);
        out_limit = 32'h3FFF_FFFF;
        repeat (2) @(negedge clk);
        #2;
        check("wd_timeout_sticky", timeout, 1);

        // Next start clears timeout; a start during FLUSH is ignored
        set_src(16'h0011, 16'h0022, 16'h0033, 16'h0044);
        expect_out(16'h0011, 11);
        expect_out(16'h0022, 12);
        d0 = done_cnt;
        start_frame(2);
        #2;
        check("ign_timeout_cleared", timeout, 0);
        wait_rel(3);
        start     = 1'b1;
        frame_len = 9;
        @(negedge clk);
        start     = 1'b0;
        frame_len = 0;
        wait_done("ign", 100);
        check("ign_done_cycle", done_rel, 12);
        check("ign_out_count", out_count, 2);
        repeat (5) @(negedge clk);
        check("ign_done_once", done_cnt - d0, 1);
        check("ign_sb_empty", sb_q.size(), 0);

        // Abort in the second RUN cycle
        sb_relaxed = 1;
        d0 = done_cnt;
        start_frame(4);
        wait_rel(10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #2;
        check("abort_busy", busy, 0);
        check("abort_src_ready", src_ready, 0);
        check("abort_fir_valid_in", fir_valid_in, 0);
        repeat (20) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);

        // start and abort together
        @(negedge clk);
        start     = 1'b1;
        abort     = 1'b1;
        frame_len = 4;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #2;
        check("start_abort_busy", busy, 0);
        repeat (5) @(negedge clk);
        #2;
        check("start_abort_still_idle", busy, 0);
        check("start_abort_no_done", done_cnt - d0, 0);

        // Asynchronous reset mid-RUN
        set_src(16'h7FFF, 16'h8000, 16'h0003, 16'h0004);
        start_frame(4);
        wait_rel(12);
        #2;
        check("pre_reset_out_count", out_count, 2);
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_src_ready", src_ready, 0);
        check("mid_rst_fir_valid_in", fir_valid_in, 0);
        check("mid_rst_fir_sample_in", fir_sample_in, 0);
        check("mid_rst_dst_data", dst_data, 0);
        check("mid_rst_out_count", out_count, 0);
        check("mid_rst_clip_count", clip_count, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        #2;
        check("post_rst_idle", busy, 0);
        check("post_rst_fir_valid_in", fir_valid_in, 0);
        check("final_sb_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
